// File: rtl/id_ex_pkg.sv
// Shared types and constants for the decode-to-execute pipeline stage.
package id_ex_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2,
    IMM_U = 2'd3
  } imm_src_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef struct packed {
    logic      regwrite;
    logic      alusrc;
    logic      memwrite;
    logic      resultsrc;
    logic      branch;
    alu_ctrl_t alucontrol;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_decode.sv
// Combinational opcode/funct decode into control bundle and immediate format.
module id_decode
  import id_ex_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output ctrl_t      ctrl,
  output imm_src_t   imm_src,
  output logic       uses_rs2
);

  logic      is_r;
  alu_ctrl_t alu_fn;

  assign is_r = (opcode == OP_R);

  // funct3 selects the ALU op for both R and I-ALU forms; only R-type can subtract
  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_fn = ALU_SLT;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  end

  always_comb begin
    ctrl     = '0;
    imm_src  = IMM_I;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_LW: begin
        ctrl.regwrite  = 1'b1;
        ctrl.alusrc    = 1'b1;
        ctrl.resultsrc = 1'b1;
      end
      OP_SW: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        imm_src       = IMM_S;
        uses_rs2      = 1'b1;
      end
      OP_R: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alucontrol = alu_fn;
        uses_rs2        = 1'b1;
      end
      OP_IALU: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = alu_fn;
      end
      OP_BEQ: begin
        ctrl.branch     = 1'b1;
        ctrl.alucontrol = ALU_SUB;
        imm_src         = IMM_B;
        uses_rs2        = 1'b1;
      end
      OP_LUI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        imm_src       = IMM_U;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage with register file, immediate generation, load-use detection
// and the ID/EX pipeline register.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned CNTW = 16,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_d,
  input  logic            valid_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pcplus4_d,
  input  logic            regwrite_w,
  input  logic [AW-1:0]   rd_w,
  input  logic [XLEN-1:0] result_w,
  input  logic            flush_e,
  input  logic            hold_e,
  output logic [7:0]      ctrl_e,
  output logic            valid_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_e,
  output logic [AW-1:0]   rs1_e,
  output logic [AW-1:0]   rs2_e,
  output logic [AW-1:0]   rd_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pcplus4_e,
  output logic            stall_d,
  output logic [CNTW-1:0] bubble_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [AW-1:0]   rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0] rd1_d, rd2_d, imm_d;
  ctrl_t           ctrl_d, ctrl_q;
  imm_src_t        imm_src;
  logic            uses_rs2;
  logic            load_use;
  logic            bubble;

  assign rs1_d = instr_d[15 +: AW];
  assign rs2_d = instr_d[20 +: AW];
  assign rd_d  = instr_d[7 +: AW];

  id_decode u_decode (
    .opcode   (instr_d[6:0]),
    .funct3   (instr_d[14:12]),
    .funct7_5 (instr_d[30]),
    .ctrl     (ctrl_d),
    .imm_src  (imm_src),
    .uses_rs2 (uses_rs2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (regwrite_w && rd_w != '0) begin
      regs[rd_w] <= result_w;
    end
  end

  // Write-through read so a same-cycle writeback is seen by decode
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (rs1_d != '0) rd1_d = (regwrite_w && rd_w == rs1_d) ? result_w : regs[rs1_d];
    if (rs2_d != '0) rd2_d = (regwrite_w && rd_w == rs2_d) ? result_w : regs[rs2_d];
  end

  always_comb begin
    imm_d = '0;
    case (imm_src)
      IMM_I: imm_d = XLEN'($signed(instr_d[31:20]));
      IMM_S: imm_d = XLEN'($signed({instr_d[31:25], instr_d[11:7]}));
      IMM_B: imm_d = XLEN'($signed({instr_d[31], instr_d[7], instr_d[30:25],
                                    instr_d[11:8], 1'b0}));
      IMM_U: imm_d = XLEN'($signed({instr_d[31:12], 12'b0}));
    endcase
  end

  assign load_use = valid_e & ctrl_q.resultsrc & ctrl_q.regwrite & (rd_e != '0) &
                    ((rd_e == rs1_d) | ((rd_e == rs2_d) & uses_rs2));
  assign stall_d  = (hold_e | load_use) & ~flush_e;
  assign bubble   = flush_e | (~hold_e & load_use);
  assign ctrl_e   = ctrl_q;

  // Flush beats hold, hold beats a load-use bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_e   <= 1'b0;
      ctrl_q    <= '0;
      rd1_e     <= '0;
      rd2_e     <= '0;
      imm_e     <= '0;
      rs1_e     <= '0;
      rs2_e     <= '0;
      rd_e      <= '0;
      pc_e      <= '0;
      pcplus4_e <= '0;
    end else if (bubble) begin
      valid_e   <= 1'b0;
      ctrl_q    <= '0;
      rd1_e     <= '0;
      rd2_e     <= '0;
      imm_e     <= '0;
      rs1_e     <= '0;
      rs2_e     <= '0;
      rd_e      <= '0;
      pc_e      <= '0;
      pcplus4_e <= '0;
    end else if (!hold_e) begin
      valid_e   <= valid_d;
      ctrl_q    <= valid_d ? ctrl_d : '0;
      rd1_e     <= rd1_d;
      rd2_e     <= rd2_d;
      imm_e     <= imm_d;
      rs1_e     <= rs1_d;
      rs2_e     <= rs2_d;
      rd_e      <= rd_d;
      pc_e      <= pc_d;
      pcplus4_e <= pcplus4_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (!flush_e && !hold_e && load_use && bubble_cnt != '1) begin
      bubble_cnt <= bubble_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage with a behavioural pipeline model.
module tb_id_ex_stage;

  localparam int CW = 192;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr_d = '0, pc_d = '0, pcplus4_d = '0, result_w = '0;
  logic        valid_d = 1'b0, regwrite_w = 1'b0, flush_e = 1'b0, hold_e = 1'b0;
  logic [4:0]  rd_w = '0;

  logic [7:0]  ctrl_e, ctrl_e2;
  logic        valid_e, valid_e2, stall_d, stall_d2;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pcplus4_e;
  logic [31:0] rd1_e2, rd2_e2, imm_e2, pc_e2, pcplus4_e2;
  logic [4:0]  rs1_e, rs2_e, rd_e, rs1_e2, rs2_e2, rd_e2;
  logic [15:0] bubble_cnt;
  logic [1:0]  bubble_cnt2;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .pc_d(pc_d),
    .pcplus4_d(pcplus4_d), .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
    .flush_e(flush_e), .hold_e(hold_e), .ctrl_e(ctrl_e), .valid_e(valid_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .pc_e(pc_e), .pcplus4_e(pcplus4_e), .stall_d(stall_d),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .pc_d(pc_d),
    .pcplus4_d(pcplus4_d), .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
    .flush_e(flush_e), .hold_e(hold_e), .ctrl_e(ctrl_e2), .valid_e(valid_e2),
    .rd1_e(rd1_e2), .rd2_e(rd2_e2), .imm_e(imm_e2), .rs1_e(rs1_e2), .rs2_e(rs2_e2),
    .rd_e(rd_e2), .pc_e(pc_e2), .pcplus4_e(pcplus4_e2), .stall_d(stall_d2),
    .bubble_cnt(bubble_cnt2)
  );

  typedef struct packed {
    bit        valid;
    bit [7:0]  ctrl;
    bit [31:0] rd1, rd2, imm;
    bit [4:0]  rs1, rs2, rd;
    bit [31:0] pc, pcp4;
    bit [31:0] cnt;
  } e_t;

  e_t        me;
  e_t        q[$];
  e_t        mon_e;
  bit [31:0] mreg [32];
  int        checks = 0;
  int        errors = 0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference decode written straight from the opcode/immediate tables
  function automatic void mdec(input bit [31:0] ins, output bit [7:0] c,
                               output bit [31:0] imm, output bit u2);
    bit [2:0] alu;
    bit [6:0] op;
    op = ins[6:0];
    case (ins[14:12])
      3'b000:  alu = (op == 7'b0110011 && ins[30]) ? 3'b001 : 3'b000;
      3'b010:  alu = 3'b101;
      3'b110:  alu = 3'b011;
      3'b111:  alu = 3'b010;
      default: alu = 3'b000;
    endcase
    imm = {{20{ins[31]}}, ins[31:20]};
    u2  = 1'b0;
    case (op)
      7'b0000011: c = {5'b11010, 3'b000};
      7'b0100011: begin c = {5'b01100, 3'b000}; u2 = 1'b1;
                        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'b0110011: begin c = {5'b10000, alu}; u2 = 1'b1; end
      7'b0010011: c = {5'b11000, alu};
      7'b1100011: begin c = {5'b00001, 3'b001}; u2 = 1'b1;
                        imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
      7'b0110111: begin c = {5'b11000, 3'b000}; imm = {ins[31:12], 12'b0}; end
      default:    c = 8'h00;
    endcase
  endfunction

  function automatic bit [31:0] enc_r(bit [6:0] f7, bit [4:0] rs2, bit [4:0] rs1,
                                      bit [2:0] f3, bit [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic bit [31:0] enc_i(bit [11:0] imm, bit [4:0] rs1, bit [2:0] f3,
                                      bit [4:0] rd, bit [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic bit [31:0] enc_s(bit [11:0] imm, bit [4:0] rs2, bit [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic bit [31:0] enc_b(bit [12:0] imm, bit [4:0] rs2, bit [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic bit [31:0] enc_u(bit [19:0] imm, bit [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic bit [31:0] rand_instr();
    bit [6:0] op, hi;
    bit [2:0] f3s [5];
    f3s = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b011};
    case ($urandom_range(0, 6))
      0: op = 7'b0000011;
      1: op = 7'b0100011;
      2: op = 7'b0110011;
      3: op = 7'b0010011;
      4: op = 7'b1100011;
      5: op = 7'b0110111;
      default: op = 7'($urandom);
    endcase
    hi = (op == 7'b0110011) ? ($urandom_range(0, 1) != 0 ? 7'h20 : 7'h00) : 7'($urandom);
    return {hi, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            f3s[$urandom_range(0, 4)], 5'($urandom_range(0, 7)), op};
  endfunction

  // Drive one decode cycle, check stall_d, and queue the expected E contents
  task automatic step(input bit [31:0] ins, input bit vd, input bit rw, input bit [4:0] rdw,
                      input bit [31:0] res, input bit fl, input bit hd);
    bit [7:0]  c;
    bit [31:0] imm, r1, r2;
    bit        u2, lu;
    bit [4:0]  s1, s2, d;
    @(negedge clk);
    rst = 1'b1;
    instr_d = ins; valid_d = vd; regwrite_w = rw; rd_w = rdw; result_w = res;
    flush_e = fl; hold_e = hd;
    pc_d = {$urandom_range(0, 32'h3fff_ffff), 2'b00}; pcplus4_d = pc_d + 32'd4;
    #1;
    mdec(ins, c, imm, u2);
    s1 = ins[19:15]; s2 = ins[24:20]; d = ins[11:7];
    lu = me.valid && me.ctrl[4] && me.ctrl[7] && me.rd != 0 &&
         (me.rd == s1 || (me.rd == s2 && u2));
    chk("stall_d", CW'(stall_d), CW'((hd || lu) && !fl));
    r1 = (s1 == 0) ? 32'd0 : (rw && rdw == s1) ? res : mreg[s1];
    r2 = (s2 == 0) ? 32'd0 : (rw && rdw == s2) ? res : mreg[s2];
    if (fl || (!hd && lu)) begin
      bit [31:0] keep;
      keep = me.cnt + ((!fl) ? 32'd1 : 32'd0);
      me = '0;
      me.cnt = keep;
    end else if (!hd) begin
      me.valid = vd; me.ctrl = vd ? c : 8'h00;
      me.rd1 = r1; me.rd2 = r2; me.imm = imm;
      me.rs1 = s1; me.rs2 = s2; me.rd = d;
      me.pc = pc_d; me.pcp4 = pcplus4_d;
    end
    q.push_back(me);
    if (rw && rdw != 0) mreg[rdw] = res;
  endtask

  task automatic rand_step();
    step(rand_instr(), $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
         5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) == 0,
         $urandom_range(0, 6) == 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid_e"}, CW'(valid_e), '0);
    chk({tag, "_ctrl_e"}, CW'(ctrl_e), '0);
    chk({tag, "_data"}, CW'({rd1_e, rd2_e, imm_e, pc_e, pcplus4_e}), '0);
    chk({tag, "_idx"}, CW'({rs1_e, rs2_e, rd_e}), '0);
    chk({tag, "_bubble_cnt"}, CW'(bubble_cnt), '0);
    chk({tag, "_bubble_cnt2"}, CW'(bubble_cnt2), '0);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk("valid_e", CW'(valid_e), CW'(mon_e.valid));
      chk("ctrl_e", CW'(ctrl_e), CW'(mon_e.ctrl));
      chk("rd1_e", CW'(rd1_e), CW'(mon_e.rd1));
      chk("rd2_e", CW'(rd2_e), CW'(mon_e.rd2));
      chk("imm_e", CW'(imm_e), CW'(mon_e.imm));
      chk("idx_e", CW'({rs1_e, rs2_e, rd_e}), CW'({mon_e.rs1, mon_e.rs2, mon_e.rd}));
      chk("pc_e", CW'({pc_e, pcplus4_e}), CW'({mon_e.pc, mon_e.pcp4}));
      chk("bubble_cnt", CW'(bubble_cnt), CW'(mon_e.cnt > 32'hffff ? 32'hffff : mon_e.cnt));
      chk("cnt2_e_fields",
          CW'({valid_e2, ctrl_e2, rd1_e2, rd2_e2, imm_e2, rs1_e2, rs2_e2, rd_e2, pc_e2, pcplus4_e2}),
          CW'({mon_e.valid, mon_e.ctrl, mon_e.rd1, mon_e.rd2, mon_e.imm, mon_e.rs1, mon_e.rs2,
               mon_e.rd, mon_e.pc, mon_e.pcp4}));
      chk("bubble_cnt2", CW'(bubble_cnt2), CW'(mon_e.cnt > 3 ? 32'd3 : mon_e.cnt));
      chk("stall_d2", CW'(stall_d2), CW'(stall_d));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    me = '0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");

    // same-cycle writeback forwarding into decode
    step(32'h0, 1'b0, 1'b1, 5'd1, 32'd100, 1'b0, 1'b0);
    step(enc_r(7'h00, 5'd5, 5'd5, 3'b000, 5'd6), 1'b1, 1'b1, 5'd5, 32'd7, 1'b0, 1'b0);
    settle();
    chk("wt_rd1", CW'(rd1_e), CW'(7));
    chk("wt_rd2", CW'(rd2_e), CW'(7));

    // load-use bubble
    step(enc_i(12'd0, 5'd1, 3'b010, 5'd3, 7'b0000011), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step(enc_r(7'h00, 5'd1, 5'd3, 3'b000, 5'd4), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("lu_stall", CW'(stall_d), CW'(1));
    settle();
    chk("lu_valid", CW'(valid_e), '0);
    chk("lu_ctrl", CW'(ctrl_e), '0);
    chk("lu_cnt", CW'(bubble_cnt), CW'(1));
    step(enc_r(7'h00, 5'd1, 5'd3, 3'b000, 5'd4), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // flush overrides hold and load-use
    step(enc_i(12'd0, 5'd1, 3'b010, 5'd3, 7'b0000011), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step(enc_r(7'h00, 5'd1, 5'd3, 3'b000, 5'd4), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    chk("fl_stall", CW'(stall_d), '0);
    settle();
    chk("fl_valid", CW'(valid_e), '0);
    chk("fl_cnt", CW'(bubble_cnt), CW'(1));

    // hold freezes a store in E
    step(enc_s(12'd4, 5'd2, 5'd1), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(rand_instr(), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      settle();
      chk("hold_stall", CW'(stall_d), CW'(1));
      chk("hold_ctrl", CW'({valid_e, ctrl_e}), CW'({1'b1, 8'h60}));
    end

    // branch and upper immediates
    step(enc_b(13'h1ff8, 5'd2, 5'd1), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    settle();
    chk("beq_imm", CW'(imm_e), CW'(32'hffff_fff8));
    chk("beq_alu", CW'(ctrl_e[2:0]), CW'(3'b001));
    step(enc_u(20'h12345, 5'd9), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    settle();
    chk("lui_imm", CW'(imm_e), CW'(32'h1234_5000));

    // five more load-use bubbles saturate the narrow counter
    for (int i = 0; i < 5; i++) begin
      step(enc_i(12'd0, 5'd0, 3'b010, 5'd7, 7'b0000011), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(enc_r(7'h00, 5'd0, 5'd7, 3'b000, 5'd8), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    end
    settle();
    chk("sat_cnt2", CW'(bubble_cnt2), CW'(3));
    chk("sat_cnt", CW'(bubble_cnt), CW'(6));

    repeat (400) rand_step();

    // asynchronous reset with a live instruction in E
    step(enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd10), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_zero("midrst");
    me = '0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    q.push_back(me);

    repeat (100) rand_step();
    settle();
    @(posedge clk);
    #3;
    chk("queue_drained", CW'(q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
